// File: rtl/store_lane_formatter.sv
// Store lane formatter: aligns store data to byte lanes, generates byte enables,
// and issues one or two word-aligned write beats over a req/ack memory port.
module store_lane_formatter #(
  parameter int ADDR_W      = 32,
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_funct,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]        off;
  logic [3:0]        base_mask;
  logic              funct_ok;
  logic [7:0]        m8;
  logic [31:0]       masked;
  logic [63:0]       d64;
  logic              split;
  logic              accept;
  logic              launch;
  logic              reject;
  logic [ADDR_W-3:0] word_addr;

  logic [ADDR_W-3:0] beat0_addr_reg, beat1_addr_reg;
  logic [31:0]       beat0_wdata_reg, beat1_wdata_reg;
  logic [3:0]        beat0_we_reg, beat1_we_reg;
  logic              split_reg;
  logic              err_reg;

  assign st_ready  = rst_n && (state_reg == IDLE);
  assign accept    = st_valid && st_ready;
  assign off       = st_addr[1:0];
  assign word_addr = st_addr[ADDR_W-1:2];

  always_comb begin
    base_mask = 4'b0000;
    funct_ok  = 1'b0;
    case (st_funct)
      3'b000:  begin base_mask = 4'b0001; funct_ok = 1'b1; end
      3'b001:  begin base_mask = 4'b0011; funct_ok = 1'b1; end
      3'b010:  begin base_mask = 4'b1111; funct_ok = 1'b1; end
      default: begin base_mask = 4'b0000; funct_ok = 1'b0; end
    endcase
  end

  // Bytes outside the access size are cleared before shifting so that
  // disabled lanes of the write data are always zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign masked[gi*8 +: 8] = base_mask[gi] ? st_data[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign m8     = {4'b0000, base_mask} << off;
  assign d64    = {32'h0000_0000, masked} << {off, 3'b000};
  assign split  = |m8[7:4];
  assign launch = accept && funct_ok && (!split || ALLOW_SPLIT);
  assign reject = accept && (!funct_ok || (split && !ALLOW_SPLIT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat0_addr_reg  <= '0;
      beat1_addr_reg  <= '0;
      beat0_wdata_reg <= '0;
      beat1_wdata_reg <= '0;
      beat0_we_reg    <= '0;
      beat1_we_reg    <= '0;
      split_reg       <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      err_reg <= reject;
      if (launch) begin
        beat0_addr_reg  <= word_addr;
        beat1_addr_reg  <= word_addr + {{(ADDR_W-3){1'b0}}, 1'b1};
        beat0_wdata_reg <= d64[31:0];
        beat1_wdata_reg <= d64[63:32];
        beat0_we_reg    <= m8[3:0];
        beat1_we_reg    <= m8[7:4];
        split_reg       <= split;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = '0;
    case (state_reg)
      IDLE: begin
        if (launch) state_next = BEAT0;
      end
      BEAT0: begin
        mem_req   = 1'b1;
        mem_addr  = beat0_addr_reg;
        mem_wdata = beat0_wdata_reg;
        mem_we    = beat0_we_reg;
        if (mem_ack) state_next = split_reg ? BEAT1 : IDLE;
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_addr  = beat1_addr_reg;
        mem_wdata = beat1_wdata_reg;
        mem_we    = beat1_we_reg;
        if (mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign err = err_reg;

endmodule

// File: tb/tb_store_lane_formatter.sv
// Directed bench for store_lane_formatter: one split-enabled instance and one
// with splitting disabled, sharing request fields.
module tb_store_lane_formatter;

  logic        clk;
  logic        rst_n;
  logic        st_valid, st_valid_ns;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct;
  logic        mem_ack, mem_ack_ns;

  logic        st_ready, st_ready_ns;
  logic        mem_req, mem_req_ns;
  logic [29:0] mem_addr, mem_addr_ns;
  logic [31:0] mem_wdata, mem_wdata_ns;
  logic [3:0]  mem_we, mem_we_ns;
  logic        err, err_ns;

  int checks = 0;
  int errors = 0;

  store_lane_formatter #(.ADDR_W(32), .ALLOW_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_funct(st_funct),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .err(err)
  );

  store_lane_formatter #(.ADDR_W(32), .ALLOW_SPLIT(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid_ns), .st_ready(st_ready_ns),
    .st_addr(st_addr), .st_data(st_data), .st_funct(st_funct),
    .mem_req(mem_req_ns), .mem_ack(mem_ack_ns), .mem_addr(mem_addr_ns),
    .mem_wdata(mem_wdata_ns), .mem_we(mem_we_ns), .err(err_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request to the split-enabled instance; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    $display("txn funct=%b addr=0x%08h data=0x%08h", f, a, d);
    st_funct = f; st_addr = a; st_data = d; st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [29:0] a, input logic [3:0] we, input logic [31:0] wd);
    check({tag, "_req"},   {63'd0, mem_req}, 64'd1);
    check({tag, "_addr"},  {34'd0, mem_addr}, {34'd0, a});
    check({tag, "_we"},    {60'd0, mem_we}, {60'd0, we});
    check({tag, "_wdata"}, {32'd0, mem_wdata}, {32'd0, wd});
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_valid_ns = 1'b0;
    st_addr = '0; st_data = '0; st_funct = '0; mem_ack = 1'b0; mem_ack_ns = 1'b0;
    repeat (2) tick();
    check("rst_ready", {63'd0, st_ready}, 64'd0);
    check("rst_req",   {63'd0, mem_req}, 64'd0);
    check("rst_we",    {60'd0, mem_we}, 64'd0);
    check("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_addr",  {34'd0, mem_addr}, 64'd0);
    check("rst_err",   {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready", {63'd0, st_ready}, 64'd1);
    tick();

    // SB at offset 3, immediate ack
    issue(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    beat("sb", 30'h400, 4'b1000, 32'hDD00_0000);
    check("sb_busy", {63'd0, st_ready}, 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_req_drop", {63'd0, mem_req}, 64'd0);
    check("sb_ready_back", {63'd0, st_ready}, 64'd1);
    check("sb_we_idle", {60'd0, mem_we}, 64'd0);

    // SH at offset 2, ack withheld three cycles
    issue(3'b001, 32'h0000_2002, 32'h1234_BEEF);
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("sh_wait%0d", i), 30'h800, 4'b1100, 32'hBEEF_0000);
      tick();
    end
    beat("sh_ack", 30'h800, 4'b1100, 32'hBEEF_0000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_done_req", {63'd0, mem_req}, 64'd0);
    check("sh_done_ready", {63'd0, st_ready}, 64'd1);
    tick();
    check("sh_no_extra", {63'd0, mem_req}, 64'd0);

    // SH at offset 1 stays in one word
    issue(3'b001, 32'h0000_0101, 32'hFFFF_5A5A);
    beat("sh1", 30'h040, 4'b0110, 32'h005A_5A00);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh1_single", {63'd0, mem_req}, 64'd0);

    // SW at offset 1 splits into two beats
    issue(3'b010, 32'h0000_0001, 32'h1122_3344);
    beat("sw_b0", 30'h0, 4'b1110, 32'h2233_4400);
    mem_ack = 1'b1;
    tick();
    beat("sw_b1", 30'h1, 4'b0001, 32'h0000_0011);
    check("sw_b1_busy", {63'd0, st_ready}, 64'd0);
    tick();
    mem_ack = 1'b0;
    check("sw_done_req", {63'd0, mem_req}, 64'd0);
    check("sw_done_ready", {63'd0, st_ready}, 64'd1);

    // Split rejected when splitting is disabled
    $display("txn nosplit funct=001 addr=0x00000007");
    st_funct = 3'b001; st_addr = 32'h0000_0007; st_data = 32'h0000_ABCD; st_valid_ns = 1'b1;
    tick();
    st_valid_ns = 1'b0;
    check("ns_err", {63'd0, err_ns}, 64'd1);
    check("ns_no_req", {63'd0, mem_req_ns}, 64'd0);
    check("ns_ready", {63'd0, st_ready_ns}, 64'd1);
    tick();
    check("ns_err_pulse", {63'd0, err_ns}, 64'd0);
    check("ns_no_req2", {63'd0, mem_req_ns}, 64'd0);

    // Unsupported funct3
    issue(3'b011, 32'h0000_0010, 32'h1111_1111);
    check("bad_err", {63'd0, err}, 64'd1);
    check("bad_no_req", {63'd0, mem_req}, 64'd0);
    check("bad_ready", {63'd0, st_ready}, 64'd1);
    tick();
    check("bad_err_pulse", {63'd0, err}, 64'd0);

    // Split at top of address space wraps beat1 to word 0
    issue(3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    beat("wrap_b0", 30'h3FFF_FFFF, 4'b1100, 32'hF00D_0000);
    mem_ack = 1'b1;
    tick();
    beat("wrap_b1", 30'h0, 4'b0011, 32'h0000_CAFE);
    tick();
    mem_ack = 1'b0;
    check("wrap_done", {63'd0, mem_req}, 64'd0);

    // Reset while beat1 waits for ack
    issue(3'b010, 32'h0000_0003, 32'hA1B2_C3D4);
    beat("rs_b0", 30'h0, 4'b1000, 32'hD400_0000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    beat("rs_b1", 30'h1, 4'b0111, 32'h00A1_B2C3);
    rst_n = 1'b0;
    #1;
    check("rs_ready_low", {63'd0, st_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("rs_req", {63'd0, mem_req}, 64'd0);
    check("rs_we", {60'd0, mem_we}, 64'd0);
    check("rs_wdata", {32'd0, mem_wdata}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rs_ready_rel", {63'd0, st_ready}, 64'd1);
    tick();
    check("rs_no_resume", {63'd0, mem_req}, 64'd0);
    issue(3'b000, 32'h0000_0005, 32'h0000_00EE);
    beat("rs_sb", 30'h1, 4'b0010, 32'h0000_EE00);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rs_sb_done", {63'd0, st_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
